// File: rtl/freq_monitor.sv
// Frequency monitor for a slow divided clock sampled in the clk_in domain.
// Measures the sig_in period in clk_in cycles, declares lock after LOCK_COUNT good periods, and flags loss of lock.
module freq_monitor #(
  parameter int INPUT_CLK_FREQ  = 25000,
  parameter int TARGET_CLK_FREQ = 64,
  parameter int TOLERANCE       = 8,
  parameter int LOCK_COUNT      = 4,
  localparam int PERIOD_NOM     = INPUT_CLK_FREQ / TARGET_CLK_FREQ,
  localparam int T_MAX          = PERIOD_NOM + TOLERANCE + 1,
  localparam int CW             = $clog2(T_MAX + 1)
) (
  input  logic          clk_in,
  input  logic          reset,
  input  logic          enable,
  input  logic          clear,
  input  logic          sig_in,
  output logic          edge_pulse,
  output logic [CW-1:0] period_out,
  output logic          period_valid,
  output logic          locked,
  output logic          lost
);

  localparam int GW   = $clog2(LOCK_COUNT + 1);
  localparam int LO_I = (PERIOD_NOM > TOLERANCE) ? (PERIOD_NOM - TOLERANCE) : 0;
  localparam int HI_I = PERIOD_NOM + TOLERANCE;

  localparam logic [CW-1:0] T_MAX_C = CW'(T_MAX);
  localparam logic [CW-1:0] LO_C    = CW'(LO_I);
  localparam logic [CW-1:0] HI_C    = CW'(HI_I);
  localparam logic [GW-1:0] LOCK_C  = GW'(LOCK_COUNT);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_EDGE = 3'd1,
    S_ACQUIRE   = 3'd2,
    S_LOCKED    = 3'd3,
    S_LOST      = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            s1_q, s2_q, s3_q;
  logic            edge_s, timeout_s, in_range_s, measure_s;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   good_q, good_d;
  logic [CW-1:0]   period_q, period_d;
  logic            pv_q, pv_d;
  logic            edge_q, locked_q, lost_q;

  assign edge_s     = s2_q & ~s3_q;
  assign timeout_s  = (cnt_q == T_MAX_C) && !edge_s;
  assign in_range_s = (cnt_q >= LO_C) && (cnt_q <= HI_C);

  // Next-state, counter and measurement logic; enable=0 overrides clear, clear overrides edge.
  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    period_d  = period_q;
    pv_d      = 1'b0;
    measure_s = 1'b0;
    if (edge_s) begin
      cnt_d = CW'(1);
    end else if (cnt_q != T_MAX_C) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end

    if (!enable) begin
      state_d = S_IDLE;
      good_d  = '0;
      cnt_d   = '0;
    end else if ((state_q == S_LOST) && clear) begin
      state_d = S_WAIT_EDGE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_WAIT_EDGE;
        S_WAIT_EDGE: begin
          if (edge_s) begin
            state_d = S_ACQUIRE;
            good_d  = '0;
          end
        end
        S_ACQUIRE: begin
          if (edge_s) begin
            measure_s = 1'b1;
            if (in_range_s) begin
              good_d = good_q + GW'(1);
              if ((good_q + GW'(1)) == LOCK_C) state_d = S_LOCKED;
            end else begin
              good_d = '0;
            end
          end else if (timeout_s) begin
            state_d = S_WAIT_EDGE;
          end
        end
        S_LOCKED: begin
          if (edge_s) begin
            measure_s = 1'b1;
            if (!in_range_s) state_d = S_LOST;
          end else if (timeout_s) begin
            state_d = S_LOST;
          end
        end
        S_LOST: begin
          if (edge_s) measure_s = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (measure_s) begin
      period_d = cnt_q;
      pv_d     = 1'b1;
    end
  end

  // Synchroniser, state and registered outputs.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      good_q   <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      edge_q   <= 1'b0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      s1_q     <= sig_in;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      good_q   <= good_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      edge_q   <= edge_s;
      locked_q <= (state_d == S_LOCKED);
      lost_q   <= (state_d == S_LOST);
    end
  end

  assign edge_pulse   = edge_q;
  assign period_out   = period_q;
  assign period_valid = pv_q;
  assign locked       = locked_q;
  assign lost         = lost_q;

endmodule

// File: tb/tb_freq_monitor.sv
// Self-checking bench for freq_monitor: a timestamp-based reference model compared every cycle,
// plus hand-computed spot checks on lock, loss, glitch, reset and enable behaviour.
module tb_freq_monitor;

  localparam int NOM   = 390;
  localparam int TOL   = 8;
  localparam int TMAX  = 399;
  localparam int LOCKN = 4;

  localparam int M_IDLE = 0, M_WAIT = 1, M_ACQ = 2, M_LOCK = 3, M_LOST = 4;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b0;
  logic       enable = 1'b0;
  logic       clear  = 1'b0;
  logic       sig_in = 1'b0;
  logic       edge_pulse, period_valid, locked, lost;
  logic [8:0] period_out;

  int n_cmp = 0;
  int n_bad = 0;

  freq_monitor dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .enable      (enable),
    .clear       (clear),
    .sig_in      (sig_in),
    .edge_pulse  (edge_pulse),
    .period_out  (period_out),
    .period_valid(period_valid),
    .locked      (locked),
    .lost        (lost)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: edges are timestamped (sig_in seen two samples late), periods are timestamp differences.
  bit   hist [40000];
  int   cyc = 3;
  int   last_edge = 0;
  int   m_mode = M_IDLE;
  int   m_good = 0;
  int   m_period = 0;
  bit   m_pulse = 1'b0;
  bit   m_pv = 1'b0;

  always @(posedge clk_in or negedge reset) begin
    int  per, dev;
    bit  ev;
    if (!reset) begin
      m_mode   = M_IDLE;
      m_good   = 0;
      m_period = 0;
      m_pulse  = 1'b0;
      m_pv     = 1'b0;
      hist[cyc-1] = 1'b0;
      hist[cyc-2] = 1'b0;
      hist[cyc-3] = 1'b0;
    end else begin
      hist[cyc] = sig_in;
      ev = hist[cyc-2] && !hist[cyc-3];
      m_pulse = ev;
      m_pv = 1'b0;
      per = cyc - last_edge;
      if (per > TMAX) per = TMAX;
      dev = (per > NOM) ? per - NOM : NOM - per;
      if (!enable) begin
        m_mode = M_IDLE;
        m_good = 0;
      end else if (m_mode == M_LOST && clear) begin
        m_mode = M_WAIT;
      end else if (m_mode == M_IDLE) begin
        m_mode = M_WAIT;
      end else if (ev) begin
        if (m_mode == M_WAIT) begin
          m_mode = M_ACQ;
          m_good = 0;
        end else begin
          m_period = per;
          m_pv = 1'b1;
          if (m_mode == M_ACQ) begin
            if (dev <= TOL) begin
              m_good++;
              if (m_good == LOCKN) m_mode = M_LOCK;
            end else begin
              m_good = 0;
            end
          end else if (m_mode == M_LOCK && dev > TOL) begin
            m_mode = M_LOST;
          end
        end
      end else if ((m_mode == M_ACQ || m_mode == M_LOCK) && (cyc - last_edge) == TMAX) begin
        m_mode = (m_mode == M_ACQ) ? M_WAIT : M_LOST;
      end
      if (enable && ev) last_edge = cyc;
      cyc++;
    end
  end

  // Per-cycle comparison of all outputs against the model, away from the active edge.
  always @(negedge clk_in) begin
    logic [12:0] exp_v, act_v;
    exp_v = {m_pulse, m_pv, (m_mode == M_LOCK), (m_mode == M_LOST), 9'(m_period)};
    act_v = {edge_pulse, period_valid, locked, lost, period_out};
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL cycle_model t=%0t got pulse/pv/lock/lost/period=%b/%b/%b/%b/%0d expected %b/%b/%b/%b/%0d",
               $time, act_v[12], act_v[11], act_v[10], act_v[9], act_v[8:0],
               exp_v[12], exp_v[11], exp_v[10], exp_v[9], exp_v[8:0]);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // One rising edge of sig_in followed by p-1 further cycles, so consecutive calls space edges by p.
  task automatic gen(input int p);
    sig_in = 1'b1;
    cyc_wait(p / 2);
    sig_in = 1'b0;
    cyc_wait(p - p / 2);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cyc_wait(1);
    clear = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc_wait(4);
    chk("reset_locked", locked, 0);
    chk("reset_period", period_out, 0);
    chk("reset_pv", period_valid, 0);
    @(negedge clk_in) reset = 1'b1;
    cyc_wait(1);

    // Nominal period locks after 1 + LOCK_COUNT edges
    enable = 1'b1;
    cyc_wait(2);
    repeat (6) gen(NOM);
    chk("t1_locked", locked, 1);
    chk("t1_period", period_out, 390);
    chk("t1_lost", lost, 0);

    // Disable while locked: IDLE, period held
    enable = 1'b0;
    cyc_wait(5);
    chk("t6_locked_drop", locked, 0);
    chk("t6_period_held", period_out, 390);
    enable = 1'b1;
    cyc_wait(3);

    // Tolerance edges accepted, 399 resets the good count
    gen(398); gen(382); gen(399);
    repeat (4) gen(NOM);
    chk("t2_no_lock_yet", locked, 0);
    gen(NOM);
    chk("t2_locked", locked, 1);

    // Hold sig_in low: timeout to LOST, next edge measures the saturated period
    cyc_wait(20);
    chk("t3_lost", lost, 1);
    chk("t3_locked", locked, 0);
    gen(50);
    chk("t3_period_sat", period_out, 399);
    pulse_clear();
    cyc_wait(2);
    chk("t3_cleared", lost, 0);

    // Glitch period while locked
    repeat (5) gen(NOM);
    gen(200); gen(NOM);
    chk("t4_period_glitch", period_out, 200);
    chk("t4_lost", lost, 1);
    pulse_clear();
    cyc_wait(2);

    // Edge exactly at T_MAX is a measurement, not a timeout
    repeat (5) gen(NOM);
    chk("t4b_locked", locked, 1);
    gen(399); gen(NOM);
    chk("t4b_period_tmax", period_out, 399);
    chk("t4b_lost", lost, 1);
    pulse_clear();
    cyc_wait(2);

    // Asynchronous reset mid-ACQUIRE
    gen(NOM); gen(NOM);
    #2 reset = 1'b0;
    #1;
    chk("t5_async_period", period_out, 0);
    chk("t5_async_lost", lost, 0);
    repeat (5) @(posedge clk_in);
    @(negedge clk_in) reset = 1'b1;
    cyc_wait(1);
    gen(NOM);
    chk("t5_first_edge_no_meas", period_out, 0);
    gen(NOM);
    chk("t5_second_edge_meas", period_out, 390);

    // Timeout in ACQUIRE falls back quietly
    cyc_wait(420);
    chk("t5_acq_timeout_lost", lost, 0);
    cyc_wait(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
